nt_node_activity_monitor: RTL and testbench
===========================================

// Module: nt_node_activity_monitor
// PURPOSE
// - Downstream observer for Nt_Node subcircuit outputs in trojan-detection benches. Samples NODE_W
//   subcircuit output nets over a programmable window of valid samples.
// - Per net: counts toggles and flags rare-activity nets (candidate trojan triggers).
// - Compresses the whole sample stream into a MISR signature for golden-vs-suspect comparison.
// PARAMETERS
// NODE_W       8        number of monitored subcircuit output nets
// WIN_W        16       width of the window-length counter
// CNT_W        12       width of each per-net toggle counter (saturating)
// RARE_THRESH  2        toggle count <= this value marks a net as rare
// MISR_POLY    8'h1D    MISR feedback polynomial (NODE_W bits)
// PORTS
// I1470_clk   in   1           single clock, all state updates on rising edge
// I1477_rst   in   1           reset; synchronous to I1470_clk, active-high
// start       in   1           begin observation window (accepted only in IDLE)
// win_len     in   WIN_W       number of valid samples in window; latched on accepted start
// node_vld    in   1           node_in carries a valid sample this cycle
// node_in     in   NODE_W      sampled subcircuit output nets
// rd_sel      in   clog2(NODE_W) selects net for tog_cnt readout
// busy        out  1           high in ARM and OBSERVE
// done        out  1           one-cycle pulse in REPORT
// err         out  1           one-cycle pulse: start with win_len==0
// rare_flag   out  NODE_W      bit i = tog_cnt[i] <= RARE_THRESH; valid from done, held until next start
// signature   out  NODE_W      final MISR value; valid from done, held until next start
// tog_cnt     out  CNT_W       toggle count of net rd_sel (combinational mux of registered counts)
// BEHAVIOUR
// - Reset (I1477_rst==1 at a clock edge):
//   - state=IDLE; busy=done=err=0; rare_flag=0; signature=0.
//   - All toggle counters=0; sample/window counters=0; prev-sample register=0.
//   - Reset overrides every other input, including mid-window; a partial window is discarded.
// - FSM states: IDLE, ARM, OBSERVE, REPORT.
//   - IDLE, start=1, win_len!=0:
//     - Latch win_len; clear counters and MISR (seed 0); go to ARM.
//   - IDLE, start=1, win_len==0: pulse err for 1 cycle; stay IDLE.
//   - ARM:
//     - First cycle with node_vld=1: capture node_in as prev; update MISR; remaining=win_len-1.
//     - No toggles are counted on this sample.
//     - If win_len==1, go to REPORT; else go to OBSERVE.
//   - OBSERVE, node_vld=1:
//     - tog_cnt[i] += (node_in[i]^prev[i]), saturating at 2^CNT_W-1 (never wraps).
//     - prev=node_in; MISR update; remaining-=1.
//     - When remaining reaches 0, go to REPORT.
//   - OBSERVE, node_vld=0: nothing advances (window counts valid samples, not cycles).
//   - REPORT (exactly 1 cycle):
//     - done=1; rare_flag and signature registered from the final counts/MISR; go to IDLE.
// - Latency: done is high in the cycle after the clock edge that consumed the last valid sample.
// - start while busy or in REPORT: ignored, no err.
// - MISR update (W=NODE_W): sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? MISR_POLY : 0) ^ node_in.
// - All arithmetic unsigned; no output depends combinationally on node_in.
// STRUCTURE
// - Package nt_mon_pkg: state enum (IDLE/ARM/OBSERVE/REPORT) and default parameter constants.
// - Sub-module nt_toggle_counter (CNT_W saturating counter with clear, inc, and sat flag).
//   - Instantiated NODE_W times via generate.
// - FSM, window counter, prev register and MISR live in this module.
// TESTING
// 1. Reset mid-window: start, win_len=10, 4 samples, assert I1477_rst 1 cycle
//    -> busy=0, all tog_cnt=0, no done.
// 2. win_len=4, node_in 8'h00,8'hFF,8'h00,8'h01 all valid
//    -> done 1 cycle after 4th sample.
//    -> tog_cnt[0]=3, tog_cnt[1..7]=2.
//    -> rare_flag=8'hFE (RARE_THRESH=2).
// 3. win_len=3, node_vld toggled 1,0,0,1,0,1
//    -> only 3 valid samples counted; done after 6th cycle; busy high throughout.
// 4. Saturation: CNT_W=4, win_len=40, net0 alternating each sample
//    -> tog_cnt[0]=15 (no wrap); rare_flag[0]=0.
// 5. start with win_len=0 -> err pulse, state stays IDLE.
//    start asserted during OBSERVE -> ignored, window completes normally.
// 6. MISR: seed 0, win_len=2, node_in 8'h01 then 8'h80, MISR_POLY=8'h1D -> signature=8'h82.

Source files
------------

// File: rtl/nt_mon_pkg.sv
// Shared types and default constants for the node activity monitor.
package nt_mon_pkg;

   localparam int unsigned NODE_W_DEF      = 8;
   localparam int unsigned WIN_W_DEF       = 16;
   localparam int unsigned CNT_W_DEF       = 12;
   localparam int unsigned RARE_THRESH_DEF = 2;
   localparam logic [7:0]  MISR_POLY_DEF   = 8'h1D;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      OBSERVE = 2'd2,
      REPORT  = 2'd3
   } mon_state_e;

endpackage

// File: rtl/nt_toggle_counter.sv
// Saturating toggle counter for one monitored net; holds at all-ones, never wraps.
module nt_toggle_counter #(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat_c
);

   assign sat_c = (cnt == '1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !sat_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Observes NODE_W subcircuit nets over a window of valid samples: per-net toggle counts,
// rare-activity flags and a MISR signature of the sample stream.
module nt_node_activity_monitor
   import nt_mon_pkg::*;
#(
   parameter int unsigned          NODE_W      = NODE_W_DEF,
   parameter int unsigned          WIN_W       = WIN_W_DEF,
   parameter int unsigned          CNT_W       = CNT_W_DEF,
   parameter int unsigned          RARE_THRESH = RARE_THRESH_DEF,
   parameter logic [NODE_W-1:0]    MISR_POLY   = NODE_W'(MISR_POLY_DEF),
   localparam int unsigned         SEL_W       = (NODE_W > 1) ? $clog2(NODE_W) : 1
) (
   input  logic              I1470_clk,
   input  logic              I1477_rst,
   input  logic              start,
   input  logic [WIN_W-1:0]  win_len,
   input  logic              node_vld,
   input  logic [NODE_W-1:0] node_in,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [NODE_W-1:0] rare_flag,
   output logic [NODE_W-1:0] signature,
   output logic [CNT_W-1:0]  tog_cnt
);

   mon_state_e        state;
   mon_state_e        state_nxt;
   logic [WIN_W-1:0]  remaining;
   logic [NODE_W-1:0] prev;
   logic [NODE_W-1:0] misr;
   logic [NODE_W-1:0] misr_nxt;
   logic [NODE_W-1:0] bump;
   logic [NODE_W-1:0] sat;
   logic [NODE_W-1:0] rare_nxt;
   logic [CNT_W-1:0]  cnt [NODE_W];
   logic              clr;
   logic              take;
   logic              count_en;
   logic              last;
   logic              err_set;

   // State register
   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; remaining==1 means the sample being taken closes the window
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start && (win_len != '0)) state_nxt = ARM;
         ARM:     if (node_vld) state_nxt = (remaining == WIN_W'(1)) ? REPORT : OBSERVE;
         OBSERVE: if (node_vld && (remaining == WIN_W'(1))) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      clr      = 1'b0;
      take     = 1'b0;
      count_en = 1'b0;
      last     = 1'b0;
      err_set  = 1'b0;
      unique case (state)
         IDLE: begin
            clr     = start && (win_len != '0);
            err_set = start && (win_len == '0);
         end
         ARM: begin
            take = node_vld;
            last = node_vld && (remaining == WIN_W'(1));
         end
         OBSERVE: begin
            take     = node_vld;
            count_en = node_vld;
            last     = node_vld && (remaining == WIN_W'(1));
         end
         default: ;
      endcase
   end

   always_comb begin
      misr_nxt = {misr[NODE_W-2:0], 1'b0} ^ (misr[NODE_W-1] ? MISR_POLY : '0) ^ node_in;
   end

   // Flags are taken from the counts as they will stand after the closing sample
   always_comb begin
      for (int i = 0; i < int'(NODE_W); i++) begin
         bump[i]     = count_en && (node_in[i] ^ prev[i]) && !sat[i];
         rare_nxt[i] = (32'(cnt[i]) + 32'(bump[i])) <= RARE_THRESH;
      end
   end

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         remaining <= '0;
         prev      <= '0;
         misr      <= '0;
         rare_flag <= '0;
         signature <= '0;
      end else begin
         busy <= (state_nxt == ARM) || (state_nxt == OBSERVE);
         done <= (state_nxt == REPORT);
         err  <= err_set;
         if (clr) begin
            remaining <= win_len;
            prev      <= '0;
            misr      <= '0;
         end
         if (take) begin
            remaining <= remaining - WIN_W'(1);
            prev      <= node_in;
            misr      <= misr_nxt;
         end
         if (last) begin
            signature <= misr_nxt;
            rare_flag <= rare_nxt;
         end
      end
   end

   for (genvar g = 0; g < int'(NODE_W); g++) begin : g_cnt
      nt_toggle_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (I1470_clk),
         .rst   (I1477_rst),
         .clr   (clr),
         .inc   (bump[g]),
         .cnt   (cnt[g]),
         .sat_c (sat[g])
      );
   end

   // Readout mux of the registered counts
   always_comb begin
      tog_cnt = '0;
      for (int i = 0; i < int'(NODE_W); i++) begin
         if (SEL_W'(i) == rd_sel) tog_cnt = cnt[i];
      end
   end

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Randomized and directed bench for nt_node_activity_monitor; two instances share stimulus,
// one with 12-bit counters and one with 4-bit counters to exercise saturation.
module tb_nt_node_activity_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] win_len;
   logic        node_vld;
   logic [7:0]  node_in;
   logic [2:0]  rd_sel;

   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [7:0]  rare_a, sig_a, rare_b, sig_b;
   logic [11:0] tog_a;
   logic [3:0]  tog_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] smp_q[$];
   logic [7:0] dir_in[$];
   bit         dir_vld[$];

   always #5 clk = ~clk;

   nt_node_activity_monitor dut_a (
      .I1470_clk(clk), .I1477_rst(rst), .start(start), .win_len(win_len),
      .node_vld(node_vld), .node_in(node_in), .rd_sel(rd_sel),
      .busy(busy_a), .done(done_a), .err(err_a), .rare_flag(rare_a),
      .signature(sig_a), .tog_cnt(tog_a)
   );

   nt_node_activity_monitor #(.CNT_W(4)) dut_b (
      .I1470_clk(clk), .I1477_rst(rst), .start(start), .win_len(win_len),
      .node_vld(node_vld), .node_in(node_in), .rd_sel(rd_sel),
      .busy(busy_b), .done(done_b), .err(err_b), .rare_flag(rare_b),
      .signature(sig_b), .tog_cnt(tog_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: toggles are differences between consecutive valid samples of the window
   task automatic check_model();
      int         raw [8];
      logic [7:0] s;
      logic [7:0] ra, rb;
      int         ca, cb;
      s = 8'h00;
      for (int j = 0; j < 8; j++) raw[j] = 0;
      for (int k = 1; k < smp_q.size(); k++)
         for (int j = 0; j < 8; j++)
            if (smp_q[k][j] != smp_q[k-1][j]) raw[j]++;
      for (int k = 0; k < smp_q.size(); k++)
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ smp_q[k];
      for (int j = 0; j < 8; j++) begin
         ca    = (raw[j] > 4095) ? 4095 : raw[j];
         cb    = (raw[j] > 15) ? 15 : raw[j];
         ra[j] = (ca <= 2);
         rb[j] = (cb <= 2);
      end
      chk("sig_a", 32'(sig_a), 32'(s));
      chk("sig_b", 32'(sig_b), 32'(s));
      chk("rare_a", 32'(rare_a), 32'(ra));
      chk("rare_b", 32'(rare_b), 32'(rb));
      for (int j = 0; j < 8; j++) begin
         rd_sel = 3'(j);
         #1;
         ca = (raw[j] > 4095) ? 4095 : raw[j];
         cb = (raw[j] > 15) ? 15 : raw[j];
         chk("tog_a", 32'(tog_a), 32'(ca));
         chk("tog_b", 32'(tog_b), 32'(cb));
      end
   endtask

   task automatic do_window(input int wl, input bit alt0, input bit poke);
      int         nv;
      int         budget;
      logic [7:0] x;
      bit         v;
      bit         a0;
      smp_q.delete();
      nv = 0;
      a0 = 1'b0;
      start = 1'b1; win_len = wl[15:0]; node_vld = 1'b0;
      tick();
      start = 1'b0;
      chk("arm_busy", 32'({busy_a, busy_b, done_a, done_b}), 32'(4'b1100));
      budget = wl * 8 + 64;
      while (nv < wl && budget > 0) begin
         budget--;
         x = 8'($urandom);
         if (dir_vld.size() > 0) begin
            v = dir_vld.pop_front();
            if (v) x = dir_in.pop_front();
         end else begin
            v = ($urandom_range(0, 9) < 7);
            if (alt0) begin
               x[0] = a0;
               if (v) a0 = ~a0;
            end
         end
         node_vld = v;
         node_in  = x;
         start    = poke && ($urandom_range(0, 3) == 0);
         win_len  = 16'($urandom_range(1, 5));
         tick();
         if (v) begin
            smp_q.push_back(x);
            nv++;
         end
         if (nv == wl) chk("done_last", 32'({done_a, done_b, busy_a, busy_b}), 32'(4'b1100));
         else          chk("mid_win",   32'({done_a, done_b, busy_a, busy_b}), 32'(4'b0011));
         node_vld = 1'b0;
         start    = 1'b0;
      end
      chk("win_samples", 32'(nv), 32'(wl));
      start = poke; win_len = 16'd5;
      tick();
      start = 1'b0;
      chk("post_report", 32'({done_a, done_b, busy_a, busy_b, err_a, err_b}), 32'(0));
      check_model();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; node_vld = 1'b0; node_in = '0; win_len = '0; rd_sel = '0;
      tick();
      tick();
      chk("rst_ctl", 32'({busy_a, done_a, err_a, busy_b, done_b, err_b}), 32'(0));
      chk("rst_flags", 32'({rare_a, sig_a, rare_b, sig_b}), 32'(0));
      rst = 1'b0;
      tick();

      // Reset mid-window discards the partial window
      start = 1'b1; win_len = 16'd10;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         node_vld = 1'b1; node_in = (k % 2 == 0) ? 8'hA5 : 8'h5A;
         tick();
      end
      node_vld = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", 32'({busy_a, done_a, busy_b, done_b}), 32'(0));
      for (int j = 0; j < 8; j++) begin
         rd_sel = 3'(j);
         tick();
         chk("rst_mid_tog", 32'({tog_a, tog_b}), 32'(0));
         chk("rst_mid_done", 32'({done_a, busy_a}), 32'(0));
      end

      // Basic window: 00,FF,00,01
      dir_in = '{8'h00, 8'hFF, 8'h00, 8'h01};
      dir_vld = '{1'b1, 1'b1, 1'b1, 1'b1};
      do_window(4, 1'b0, 1'b0);
      chk("t2_rare", 32'(rare_a), 32'(8'hFE));
      rd_sel = 3'd0; #1;
      chk("t2_tog0", 32'(tog_a), 32'(3));
      rd_sel = 3'd5; #1;
      chk("t2_tog5", 32'(tog_a), 32'(2));

      // Gaps in node_vld do not advance the window
      dir_in = '{8'h3C, 8'hC3, 8'h3C};
      dir_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      do_window(3, 1'b0, 1'b0);

      // Saturation on the 4-bit instance
      do_window(40, 1'b1, 1'b0);
      rd_sel = 3'd0; #1;
      chk("t4_sat_b", 32'(tog_b), 32'(15));
      chk("t4_rare_b0", 32'(rare_b[0]), 32'(0));
      chk("t4_cnt_a", 32'(tog_a), 32'(39));

      // Zero-length start and start while busy
      start = 1'b1; win_len = 16'd0;
      tick();
      start = 1'b0;
      chk("err_pulse", 32'({err_a, err_b, busy_a, busy_b}), 32'(4'b1100));
      tick();
      chk("err_clear", 32'({err_a, err_b, busy_a, busy_b}), 32'(0));
      do_window(6, 1'b0, 1'b1);

      // MISR known value
      dir_in = '{8'h01, 8'h80};
      dir_vld = '{1'b1, 1'b1};
      do_window(2, 1'b0, 1'b0);
      chk("t6_sig", 32'(sig_a), 32'(8'h82));

      do_window(1, 1'b0, 1'b0);

      for (int r = 0; r < 20; r++)
         do_window($urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
